// File: rtl/mps_row_scheduler.sv
// Row readout sequencer: walks the rows of a frame, latches the column hit
// flags of each row and serialises every hit as a 24-bit word over valid/ready.
module mps_row_scheduler #(
  parameter int unsigned ROWS   = 128,
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] hit_flags,
  input  logic        hit_ready,
  output logic [6:0]  row_addr,
  output logic        row_en,
  output logic [31:0] col_clear,
  output logic        hit_valid,
  output logic [23:0] hit_data,
  output logic        frame_done,
  output logic        busy
);

  localparam int unsigned ROW_W = 7;
  localparam int unsigned COL_W = 5;
  localparam int unsigned FC_W  = 12;
  localparam int unsigned NCOL  = 32;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LATCH,
    S_ARB,
    S_NEXT
  } state_t;

  state_t            state;
  logic [NCOL-1:0]   pending;
  logic              stop_req;
  logic [CNT_W-1:0]  settle_cnt;
  logic [FC_W-1:0]   frame_cnt;

  logic              accept;
  logic              last_row;
  logic [COL_W-1:0]  cur_col;
  logic [COL_W-1:0]  nxt_col;
  logic [NCOL-1:0]   nxt_pending;

  // Index of the lowest set bit; zero when no bit is set.
  function automatic logic [COL_W-1:0] lowest_col(input logic [NCOL-1:0] v);
    lowest_col = '0;
    for (int i = NCOL - 1; i >= 0; i--) begin
      if (v[i]) lowest_col = COL_W'(i);
    end
  endfunction

  // Pending-set update and the column the next word will carry.
  always_comb begin
    accept      = hit_valid && hit_ready;
    last_row    = (row_addr == ROW_W'(ROWS - 1));
    cur_col     = lowest_col(pending);
    nxt_pending = pending;
    if (state == S_LATCH) begin
      nxt_pending = hit_flags;
    end else if ((state == S_ARB) && accept) begin
      nxt_pending = pending & ~(NCOL'(1) << cur_col);
    end
    nxt_col = lowest_col(nxt_pending);
  end

  // Scan FSM; every output is registered and set on the transition into its cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      row_addr   <= '0;
      row_en     <= 1'b0;
      col_clear  <= '0;
      hit_valid  <= 1'b0;
      hit_data   <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      pending    <= '0;
      stop_req   <= 1'b0;
      settle_cnt <= '0;
      frame_cnt  <= '0;
    end else begin
      col_clear  <= '0;
      frame_done <= 1'b0;
      pending    <= nxt_pending;
      if (state != S_IDLE) stop_req <= stop_req | stop;

      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_SELECT;
            row_addr   <= '0;
            row_en     <= 1'b1;
            busy       <= 1'b1;
            settle_cnt <= '0;
          end
        end

        S_SELECT: begin
          if (settle_cnt == CNT_W'(SETTLE - 1)) begin
            state <= S_LATCH;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end

        S_LATCH: begin
          state     <= S_ARB;
          hit_valid <= (nxt_pending != '0);
          if (nxt_pending != '0) hit_data <= {row_addr, nxt_col, frame_cnt};
        end

        S_ARB: begin
          if (accept) col_clear <= NCOL'(1) << cur_col;
          if (pending == '0) begin
            state      <= S_NEXT;
            row_en     <= 1'b0;
            hit_valid  <= 1'b0;
            frame_done <= last_row;
          end else begin
            hit_valid <= (nxt_pending != '0);
            if (nxt_pending != '0) hit_data <= {row_addr, nxt_col, frame_cnt};
          end
        end

        S_NEXT: begin
          if (!last_row) begin
            row_addr   <= row_addr + ROW_W'(1);
            state      <= S_SELECT;
            row_en     <= 1'b1;
            settle_cnt <= '0;
          end else begin
            frame_cnt <= frame_cnt + FC_W'(1);
            row_addr  <= '0;
            if (stop_req || stop) begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              stop_req <= 1'b0;
            end else begin
              state      <= S_SELECT;
              row_en     <= 1'b1;
              settle_cnt <= '0;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
